// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-side bundle: branch redirect and IF/ID handshake plus the instruction-bus
// request/grant/response signals. The fetch unit is the master.
interface fetch_prefetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              br;
  logic [ADDR_W-1:0] br_addr;
  logic              out_pop;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [INST_W-1:0] mem_rdata;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    input  br, br_addr, out_pop, mem_gnt, mem_rvalid, mem_rdata,
    output mem_req, mem_addr, out_valid, out_inst, out_pc
  );

  modport slave (
    output br, br_addr, out_pop, mem_gnt, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues pipelined fetches, buffers PC-tagged words
// in order, and on a taken branch flushes the queue and discards in-flight responses.
module fetch_prefetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                    clk,
  input logic                    rst,
  fetch_prefetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [INST_W-1:0] inst_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  ptr_t              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t              count_q, count_d;
  cnt_t              inflight_q, inflight_d;
  cnt_t              discard_q, discard_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic              req_q, req_d;
  logic              grant, push, pop;

  assign bus.mem_req   = req_q && !bus.br;
  assign bus.mem_addr  = fetch_pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_inst  = bus.out_valid ? inst_q[rd_ptr_q] : '0;
  assign bus.out_pc    = bus.out_valid ? pc_q[rd_ptr_q]   : '0;

  always_comb begin
    grant      = bus.mem_req && bus.mem_gnt;
    push       = bus.mem_rvalid && (discard_q == '0) && !bus.br;
    pop        = bus.out_pop && (count_q != '0) && !bus.br;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + cnt_t'(grant) - cnt_t'(bus.mem_rvalid);
    if (bus.br) begin
      // Everything still outstanding belongs to the old path, including a word landing now.
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = bus.br_addr;
      resp_pc_d  = bus.br_addr;
      discard_d  = inflight_q - cnt_t'(bus.mem_rvalid);
    end else begin
      count_d  = count_q + cnt_t'(push) - cnt_t'(pop);
      rd_ptr_d = rd_ptr_q + ptr_t'(pop);
      wr_ptr_d = wr_ptr_q + ptr_t'(push);
      if (grant) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (push)  resp_pc_d  = resp_pc_q + ADDR_W'(4);
      if (bus.mem_rvalid && (discard_q != '0)) discard_d = discard_q - cnt_t'(1);
    end
    // Reserving a slot per outstanding request makes queue overflow impossible.
    req_d = (count_d + inflight_d) < DEPTH_C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      req_q      <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr_q] <= bus.mem_rdata;
      pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (discard_q <= inflight_q);
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: cycle tables for the streaming cases, directed
// sequences for branch/stall/reset corners, and a scoreboard of expected fetch PCs.
module tb_fetch_prefetch_queue;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  fetch_prefetch_queue #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        gnt;
    logic        pop;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  pend_t       pend[$];
  logic [31:0] expq[$];
  logic [31:0] exp_fetch;
  vec_t        tbl [16];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          lat   = 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bus();
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = word_of(pend[0].addr);
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
  endtask

  // Inputs for the current cycle are already driven; observe, advance, start next cycle.
  task automatic finish_cycle();
    logic [31:0] e;
    @(negedge clk);
    if (rst) begin
      expq.delete();
      pend.delete();
      exp_fetch = RESET_PC;
    end else begin
      if (bus.br) begin
        chk("req_in_br", bus.mem_req, 1'b0);
        expq.delete();
        exp_fetch = bus.br_addr;
      end else if (bus.out_pop && bus.out_valid) begin
        if (expq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_unexpected: got pc %h, required no valid entry (cycle %0d)", bus.out_pc, cyc);
        end else begin
          e = expq.pop_front();
          chk("pop_pc", bus.out_pc, e);
          chk("pop_inst", bus.out_inst, word_of(e));
        end
      end
      if (!bus.out_valid) begin
        chk("idle_pc", bus.out_pc, 32'h0);
        chk("idle_inst", bus.out_inst, 32'h0);
      end
      if (bus.mem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (bus.mem_req && bus.mem_gnt) begin
        chk("grant_addr", bus.mem_addr, exp_fetch);
        pend.push_back('{addr: bus.mem_addr, due: cyc + lat});
        expq.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_bus();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.br      = 1'b0;
    bus.out_pop = 1'b0;
    bus.mem_gnt = 1'b0;
    pend.delete();
    drive_bus();
    finish_cycle();
    #1;
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_inst", bus.out_inst, 32'h0);
    chk("rst_addr", bus.mem_addr, RESET_PC);
    finish_cycle();
    rst       = 1'b0;
    cyc       = 0;
    lat       = 1;
    exp_fetch = RESET_PC;
    drive_bus();
  endtask

  task automatic run_vec(input int i);
    bus.mem_gnt = tbl[i].gnt;
    bus.out_pop = tbl[i].pop;
    bus.br      = 1'b0;
    #2;
    chk($sformatf("v%0d_req", i), bus.mem_req, tbl[i].req);
    chk($sformatf("v%0d_addr", i), bus.mem_addr, tbl[i].addr);
    chk($sformatf("v%0d_valid", i), bus.out_valid, tbl[i].vld);
    chk($sformatf("v%0d_pc", i), bus.out_pc, tbl[i].pc);
    finish_cycle();
  endtask

  // Wait (bounded) for the first valid head entry; report when and what it was.
  task automatic wait_valid(input string name, input int want_cyc, input logic [31:0] want_pc);
    for (int k = 0; k < 16 && !bus.out_valid; k++) finish_cycle();
    #2;
    chk({name, "_cycle"}, cyc, want_cyc);
    chk({name, "_pc"}, bus.out_pc, want_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.br_addr    = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    exp_fetch      = RESET_PC;

    // Streaming with pop held high: first word valid at cycle 3, then one per cycle.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    // Queue fills with no pops: four grants then requests stop until a slot frees.
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h4};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(i);
    do_reset();
    for (int i = 6; i < 16; i++) run_vec(i);

    // Branch with three requests in flight and no response in the branch cycle.
    do_reset();
    lat = 4;
    bus.mem_gnt = 1'b1;
    repeat (4) finish_cycle();
    bus.br = 1'b1;
    bus.br_addr = 32'h100;
    #2;
    chk("br3_req", bus.mem_req, 1'b0);
    finish_cycle();
    bus.br = 1'b0;
    #2;
    chk("br3_req_next", bus.mem_req, 1'b1);
    chk("br3_addr_next", bus.mem_addr, 32'h100);
    wait_valid("br3_first", 10, 32'h100);
    bus.out_pop = 1'b1;
    repeat (8) finish_cycle();

    // Branch, response and pop all in the same cycle.
    do_reset();
    lat = 2;
    bus.mem_gnt = 1'b1;
    repeat (4) finish_cycle();
    bus.br = 1'b1;
    bus.br_addr = 32'h200;
    bus.out_pop = 1'b1;
    #2;
    chk("brx_rvalid_present", bus.mem_rvalid, 1'b1);
    chk("brx_valid_before", bus.out_valid, 1'b1);
    chk("brx_pc_before", bus.out_pc, 32'h0);
    finish_cycle();
    bus.br = 1'b0;
    bus.out_pop = 1'b0;
    #2;
    chk("brx_flushed", bus.out_valid, 1'b0);
    chk("brx_addr_next", bus.mem_addr, 32'h200);
    wait_valid("brx_first", 8, 32'h200);
    bus.out_pop = 1'b1;
    repeat (6) finish_cycle();

    // Grant withheld for five cycles with a request pending at 0x20.
    do_reset();
    bus.mem_gnt = 1'b1;
    bus.out_pop = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.mem_req && bus.mem_addr == 32'h20) break;
      finish_cycle();
    end
    chk("stall_reach", bus.mem_addr, 32'h20);
    bus.mem_gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("stall_req", bus.mem_req, 1'b1);
      chk("stall_addr", bus.mem_addr, 32'h20);
      finish_cycle();
    end
    bus.mem_gnt = 1'b1;
    #2;
    chk("stall_grant_addr", bus.mem_addr, 32'h20);
    finish_cycle();
    #2;
    chk("stall_after_addr", bus.mem_addr, 32'h24);
    repeat (4) finish_cycle();

    // Reset while two entries are queued and two requests are outstanding.
    do_reset();
    lat = 2;
    bus.mem_gnt = 1'b1;
    repeat (5) finish_cycle();
    #2;
    chk("midrst_valid_before", bus.out_valid, 1'b1);
    do_reset();
    bus.mem_gnt = 1'b1;
    bus.out_pop = 1'b1;
    finish_cycle();
    #2;
    chk("midrst_restart_req", bus.mem_req, 1'b1);
    chk("midrst_restart_addr", bus.mem_addr, RESET_PC);
    wait_valid("midrst_first", 3, RESET_PC);
    repeat (10) finish_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
